motor_ramp_ctrl: RTL and testbench

Speed-ramp controller for the elevator hoist motor. Sits between the elevator control FSM and the PWM generator: it converts a run request and direction into a 2-bit duty-cycle code (00 = 0 %, 01 = 25 %, 10 = 50 %, 11 = 75 %) that steps up and down one level at a time. This gives soft starts and stops. Direction is latched only while the motor is stopped, so the motor never reverses under drive.

---
 rtl/motor_pkg.sv | 8 +
 rtl/step_timer.sv | 15 +
 rtl/motor_ramp_ctrl.sv | 78 +++++++
 tb/tb_motor_ramp_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and duty-code constants for the hoist motor ramp controller
package motor_pkg;
  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, HALT} state_t;
  localparam logic [1:0] DUTY_0  = 2'b00;
  localparam logic [1:0] DUTY_25 = 2'b01;
  localparam logic [1:0] DUTY_50 = 2'b10;
  localparam logic [1:0] DUTY_75 = 2'b11;
endpackage

// File: rtl/step_timer.sv
// step_timer: prescaler counting 0..STEP_CYCLES-1, tick at terminal count; ports Clk, Reset, clr (sync clear), tick
module step_timer #(
  parameter int STEP_CYCLES = 64
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(STEP_CYCLES - 1);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: soft start/stop duty ramp for the hoist motor, direction latched only when stopped
// Ports: Clk, Reset (async, active-high), Move, DirReq, EStop (only with MOTOR_ESTOP_EN),
//        DutyCycle[1:0], MotorDir, AtSpeed, Stopped
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int STEP_CYCLES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Move,
  input  logic       DirReq,
`ifdef MOTOR_ESTOP_EN
  input  logic       EStop,
`endif
  output logic [1:0] DutyCycle,
  output logic       MotorDir,
  output logic       AtSpeed,
  output logic       Stopped
);
  state_t     state, state_n;
  logic [1:0] duty_n;
  logic       dir_n, tick, clr, halt_req;
`ifdef MOTOR_ESTOP_EN
  assign halt_req = EStop;
`else
  assign halt_req = 1'b0;
`endif
  // Prescaler restarts on every state change and is held idle while parked
  assign clr = (state_n != state) || (state == IDLE) || (state == HALT);
  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .Clk  (Clk),
    .Reset(Reset),
    .clr  (clr),
    .tick (tick)
  );
  always_comb begin
    state_n = state;
    duty_n  = DutyCycle;
    dir_n   = MotorDir;
    case (state)
      IDLE: if (Move) begin
        state_n = ACCEL;
        dir_n   = DirReq;
      end
      ACCEL: if (!Move) state_n = DECEL;
      else if (tick) begin
        duty_n  = (DutyCycle == DUTY_75) ? DUTY_75 : DutyCycle + 2'd1;
        state_n = (duty_n == DUTY_75) ? CRUISE : ACCEL;
      end
      CRUISE: state_n = Move ? CRUISE : DECEL;
      // A reverse request is ignored here; it is re-sampled once IDLE is reached
      DECEL: if (Move && DirReq == MotorDir) state_n = ACCEL;
      else if (tick) begin
        duty_n  = (DutyCycle == DUTY_0) ? DUTY_0 : DutyCycle - 2'd1;
        state_n = (duty_n == DUTY_0) ? IDLE : DECEL;
      end
      HALT: state_n = Move ? HALT : IDLE;
      default: state_n = IDLE;
    endcase
    if (halt_req) begin
      state_n = HALT;
      duty_n  = DUTY_0;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state     <= IDLE;
      DutyCycle <= DUTY_0;
      MotorDir  <= 1'b0;
    end else begin
      state     <= state_n;
      DutyCycle <= duty_n;
      MotorDir  <= dir_n;
    end
  assign AtSpeed = state == CRUISE;
  assign Stopped = state == IDLE;
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed and randomized checks of motor_ramp_ctrl against a behavioural ramp model
module tb_motor_ramp_ctrl;
  localparam int S = 4;
  localparam int M_IDLE = 0, M_UP = 1, M_CRUISE = 2, M_DOWN = 3, M_HALT = 4;
  logic       Clk = 1'b0, Reset = 1'b1, Move = 1'b0, DirReq = 1'b0, EStop = 1'b0;
  logic [1:0] DutyCycle;
  logic       MotorDir, AtSpeed, Stopped;
  int n_chk = 0, n_pass = 0;
  int m_mode = M_IDLE, m_duty = 0, m_t = 0;
  bit m_dir = 1'b0;
  motor_ramp_ctrl #(.STEP_CYCLES(S)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Move     (Move),
    .DirReq   (DirReq),
`ifdef MOTOR_ESTOP_EN
    .EStop    (EStop),
`endif
    .DutyCycle(DutyCycle),
    .MotorDir (MotorDir),
    .AtSpeed  (AtSpeed),
    .Stopped  (Stopped)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask
  task automatic model_reset();
    m_mode = M_IDLE; m_duty = 0; m_t = 0; m_dir = 1'b0;
  endtask
  // One clock edge of the ramp rules, with elapsed-cycle count t inside the current phase
  task automatic model_step();
    bit es = 1'b0;
`ifdef MOTOR_ESTOP_EN
    es = EStop;
`endif
    if (es) begin
      m_mode = M_HALT; m_duty = 0; m_t = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (Move) begin m_mode = M_UP; m_dir = DirReq; m_t = 0; end
      M_UP:
        if (!Move) begin m_mode = M_DOWN; m_t = 0; end
        else if (m_t == S - 1) begin
          m_duty = (m_duty + 1 > 3) ? 3 : m_duty + 1;
          m_t = 0;
          if (m_duty == 3) m_mode = M_CRUISE;
        end else m_t++;
      M_CRUISE: if (!Move) begin m_mode = M_DOWN; m_t = 0; end
      M_DOWN:
        if (Move && DirReq == m_dir) begin m_mode = M_UP; m_t = 0; end
        else if (m_t == S - 1) begin
          m_duty = (m_duty - 1 < 0) ? 0 : m_duty - 1;
          m_t = 0;
          if (m_duty == 0) m_mode = M_IDLE;
        end else m_t++;
      default: if (!Move) m_mode = M_IDLE;
    endcase
  endtask
  task automatic check_outputs();
    check("duty", DutyCycle, m_duty);
    check("dir", MotorDir, m_dir);
    check("atspeed", AtSpeed, m_mode == M_CRUISE);
    check("stopped", Stopped, m_mode == M_IDLE);
  endtask
  // Starts and ends on a falling edge; tog flips DirReq every cycle
  task automatic drive(input bit m, input bit d, input int n, input bit tog = 1'b0);
    DirReq = d;
    for (int i = 0; i < n; i++) begin
      Move = m;
      if (tog) DirReq = ~DirReq;
      @(posedge Clk);
      model_step();
      #1 check_outputs();
      @(negedge Clk);
    end
  endtask
  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_duty", DutyCycle, 0);
    check("rst_stopped", Stopped, 1);
    check("rst_atspeed", AtSpeed, 0);
    check("rst_dir", MotorDir, 0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    pulse_reset();
    drive(1'b1, 1'b1, 13);
    check("rampup_duty", DutyCycle, 3);
    check("rampup_atspeed", AtSpeed, 1);
    check("rampup_dir", MotorDir, 1);
    drive(1'b1, 1'b1, 8);
    drive(1'b0, 1'b1, 13);
    check("rampdown_stopped", Stopped, 1);
    check("rampdown_duty", DutyCycle, 0);
    drive(1'b1, 1'b1, 13);
    drive(1'b0, 1'b1, 9);
    check("decel_duty", DutyCycle, 1);
    drive(1'b1, 1'b1, 5);
    check("resume_duty", DutyCycle, 2);
    drive(1'b1, 1'b1, 4);
    check("resume_cruise", DutyCycle, 3);
    drive(1'b0, 1'b1, 9);
    drive(1'b1, 1'b0, 4);
    check("rev_stopped", Stopped, 1);
    check("rev_olddir", MotorDir, 1);
    drive(1'b1, 1'b0, 1);
    check("rev_newdir", MotorDir, 0);
    check("rev_accel", Stopped, 0);
    drive(1'b1, 1'b0, 12);
    drive(1'b1, 1'b0, 10, 1'b1);
    check("tog_dir", MotorDir, 0);
    check("tog_duty", DutyCycle, 3);
    drive(1'b0, 1'b0, 5);
    check("pre_reset_duty", DutyCycle, 2);
    pulse_reset();
    drive(1'b0, 1'b0, 6);
    check("post_reset_duty", DutyCycle, 0);
`ifdef MOTOR_ESTOP_EN
    drive(1'b1, 1'b1, 13);
    EStop = 1'b1;
    drive(1'b1, 1'b1, 1);
    check("estop_duty", DutyCycle, 0);
    check("estop_stopped", Stopped, 0);
    EStop = 1'b0;
    drive(1'b1, 1'b1, 5);
    check("halt_hold", Stopped, 0);
    drive(1'b0, 1'b1, 1);
    check("halt_exit", Stopped, 1);
`endif
    repeat (80) begin
`ifdef MOTOR_ESTOP_EN
      EStop = ($urandom_range(0, 15) == 0);
`endif
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 20),
            ($urandom_range(0, 3) == 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
